dma_priority_arbiter: RTL and testbench

Four-channel request arbiter and bus-hold sequencer for the DMA controller. It resolves DREQ and software requests under fixed or rotating priority and runs the HRQ/HLDA handshake with the CPU. It then drives the one-hot DACK for the winning channel until timing control signals end of service. It sits between the command/mask/request registers and the timing-control state machine, and replaces the ad-hoc priority logic.

---
 rtl/dma_pkg.sv | 30 +++
 rtl/dma_priority_encoder.sv | 33 +++
 rtl/dma_priority_arbiter.sv | 143 ++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA priority arbiter.
// Holds the FSM state enum, channel sizing, the reset/fixed priority order
// and the rotation helper used after a completed service.
package dma_pkg;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned ORDER_W = NUM_CH * CH_W;

    // [1:0] = highest-priority channel, [7:6] = lowest
    localparam logic [ORDER_W-1:0] DEFAULT_PRIORITY_ORDER = 8'b11_10_01_00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_REQ = 2'd1,
        SERVICE  = 2'd2
    } state_e;

    // Served channel drops to lowest priority; the next channel up becomes highest.
    function automatic logic [ORDER_W-1:0] rotate(input logic [CH_W-1:0] served);
        logic [CH_W-1:0] p1;
        logic [CH_W-1:0] p2;
        logic [CH_W-1:0] p3;
        p1 = served + CH_W'(1);
        p2 = served + CH_W'(2);
        p3 = served + CH_W'(3);
        return {served, p3, p2, p1};
    endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational priority encoder: picks the first channel in priorityOrder
// (scanning from the highest-priority field) whose effective request is set.
// Ports:
//   effReq        in  effective request per channel
//   priorityOrder in  packed order, [1:0] highest .. [7:6] lowest
//   anyReq        out at least one effective request present
//   winner        out index of the winning channel (0 when anyReq=0)
module dma_priority_encoder
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0]  effReq,
    input  logic [ORDER_W-1:0] priorityOrder,
    output logic               anyReq,
    output logic [CH_W-1:0]    winner
);

    logic [CH_W-1:0] slot_ch;

    // First hit in slot order wins; later slots are ignored once found.
    always_comb begin
        anyReq  = 1'b0;
        winner  = '0;
        slot_ch = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            slot_ch = priorityOrder[i*CH_W +: CH_W];
            if (!anyReq && effReq[slot_ch]) begin
                anyReq = 1'b1;
                winner = slot_ch;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter and bus-hold sequencer.
// Resolves hardware/software requests under fixed or rotating priority, runs
// the HRQ/HLDA handshake and drives a one-hot DACK until end of service.
// Ports:
//   CLK, RESET_N       clock, synchronous active-low reset
//   DREQ               raw hardware requests
//   dreqSenseLow       1 = DREQ active-low
//   priorityType       0 = fixed, 1 = rotating
//   controllerDisable  blocks new arbitration
//   maskReg            masks hardware requests
//   requestReg         software requests (not maskable)
//   HLDA               hold acknowledge from CPU
//   transferDone       end-of-service pulse from timing control
//   HRQ                hold request to CPU
//   DACK               one-hot acknowledge
//   grantValid         a channel owns the bus
//   grantCh            latched winner index
//   priorityOrder      current priority order
module dma_priority_arbiter
    import dma_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_CH-1:0]  DREQ,
    input  logic               dreqSenseLow,
    input  logic               priorityType,
    input  logic               controllerDisable,
    input  logic [NUM_CH-1:0]  maskReg,
    input  logic [NUM_CH-1:0]  requestReg,
    input  logic               HLDA,
    input  logic               transferDone,
    output logic               HRQ,
    output logic [NUM_CH-1:0]  DACK,
    output logic               grantValid,
    output logic [CH_W-1:0]    grantCh,
    output logic [ORDER_W-1:0] priorityOrder
);

    state_e               state_q, state_d;
    logic                 hrq_q, hrq_d;
    logic [NUM_CH-1:0]    dack_q, dack_d;
    logic                 gv_q, gv_d;
    logic [CH_W-1:0]      gch_q, gch_d;
    logic [ORDER_W-1:0]   order_q, order_d;

    logic [NUM_CH-1:0]    eff_req;
    logic                 any_req;
    logic [CH_W-1:0]      winner;

    // Polarity-corrected, masked hardware requests plus software requests.
    assign eff_req = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | requestReg;

    dma_priority_encoder u_enc (
        .effReq        (eff_req),
        .priorityOrder (order_q),
        .anyReq        (any_req),
        .winner        (winner)
    );

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            hrq_q   <= 1'b0;
            dack_q  <= '0;
            gv_q    <= 1'b0;
            gch_q   <= '0;
            order_q <= DEFAULT_PRIORITY_ORDER;
        end else begin
            state_q <= state_d;
            hrq_q   <= hrq_d;
            dack_q  <= dack_d;
            gv_q    <= gv_d;
            gch_q   <= gch_d;
            order_q <= order_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        hrq_d   = hrq_q;
        dack_d  = dack_q;
        gv_d    = gv_q;
        gch_d   = gch_q;
        // Fixed mode pins the order every cycle; rotating mode holds it.
        order_d = priorityType ? order_q : DEFAULT_PRIORITY_ORDER;

        unique case (state_q)
            IDLE: begin
                hrq_d  = 1'b0;
                dack_d = '0;
                gv_d   = 1'b0;
                if (any_req && !controllerDisable) begin
                    state_d = HOLD_REQ;
                    hrq_d   = 1'b1;
                    gch_d   = winner;
                end
            end
            HOLD_REQ: begin
                // Winner stays latched; only its own request or a disable cancels.
                if (!eff_req[gch_q] || controllerDisable) begin
                    state_d = IDLE;
                    hrq_d   = 1'b0;
                end else if (HLDA) begin
                    state_d = SERVICE;
                    gv_d    = 1'b1;
                    dack_d  = NUM_CH'(1) << gch_q;
                end
            end
            SERVICE: begin
                // Completion takes precedence over a simultaneous HLDA drop.
                if (transferDone) begin
                    state_d = IDLE;
                    hrq_d   = 1'b0;
                    dack_d  = '0;
                    gv_d    = 1'b0;
                    if (priorityType) begin
                        order_d = rotate(gch_q);
                    end
                end else if (!HLDA) begin
                    state_d = IDLE;
                    hrq_d   = 1'b0;
                    dack_d  = '0;
                    gv_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                hrq_d   = 1'b0;
                dack_d  = '0;
                gv_d    = 1'b0;
            end
        endcase
    end

    assign HRQ           = hrq_q;
    assign DACK          = dack_q;
    assign grantValid    = gv_q;
    assign grantCh       = gch_q;
    assign priorityOrder = order_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the arbiter.
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] DREQ = 4'b0;
    logic       dreqSenseLow = 1'b0;
    logic       priorityType = 1'b0;
    logic       controllerDisable = 1'b0;
    logic [3:0] maskReg = 4'b0;
    logic [3:0] requestReg = 4'b0;
    logic       HLDA = 1'b0;
    logic       transferDone = 1'b0;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantCh;
    logic [7:0] priorityOrder;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: phase 0 = idle, 1 = waiting for HLDA, 2 = bus owned.
    int m_phase = 0;
    int m_ch    = 0;
    int m_ord[4] = '{0, 1, 2, 3};   // m_ord[0] = highest priority

    logic [7:0] saved_order;

    dma_priority_arbiter dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .DREQ              (DREQ),
        .dreqSenseLow      (dreqSenseLow),
        .priorityType      (priorityType),
        .controllerDisable (controllerDisable),
        .maskReg           (maskReg),
        .requestReg        (requestReg),
        .HLDA              (HLDA),
        .transferDone      (transferDone),
        .HRQ               (HRQ),
        .DACK              (DACK),
        .grantValid        (grantValid),
        .grantCh           (grantCh),
        .priorityOrder     (priorityOrder)
    );

    always #5 CLK = ~CLK;

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        bit req[4];
        bit any;
        int win;
        if (!RESET_N) begin
            m_phase = 0;
            m_ch    = 0;
            for (int i = 0; i < 4; i++) m_ord[i] = i;
            return;
        end
        for (int c = 0; c < 4; c++) begin
            bit asserted;
            asserted = dreqSenseLow ? !DREQ[c] : DREQ[c];
            req[c] = (asserted && !maskReg[c]) || requestReg[c];
        end
        any = 0;
        win = 0;
        for (int i = 3; i >= 0; i--) begin
            if (req[m_ord[i]]) begin
                any = 1;
                win = m_ord[i];
            end
        end
        case (m_phase)
            0: if (any && !controllerDisable) begin
                   m_ch    = win;
                   m_phase = 1;
               end
            1: if (!req[m_ch] || controllerDisable) m_phase = 0;
               else if (HLDA) m_phase = 2;
            2: if (transferDone) begin
                   m_phase = 0;
                   if (priorityType) begin
                       m_ord[0] = (m_ch + 1) % 4;
                       m_ord[1] = (m_ch + 2) % 4;
                       m_ord[2] = (m_ch + 3) % 4;
                       m_ord[3] = m_ch;
                   end
               end else if (!HLDA) begin
                   m_phase = 0;
               end
            default: m_phase = 0;
        endcase
        if (!priorityType) begin
            for (int i = 0; i < 4; i++) m_ord[i] = i;
        end
    endtask

    function automatic logic [7:0] model_order();
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = 2'(m_ord[i]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_model();
        check("HRQ",           8'(HRQ),        8'(m_phase != 0));
        check("grantValid",    8'(grantValid), 8'(m_phase == 2));
        check("DACK",          8'(DACK),       (m_phase == 2) ? 8'(1 << m_ch) : 8'h00);
        check("grantCh",       8'(grantCh),    8'(m_ch));
        check("priorityOrder", priorityOrder,  model_order());
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_model();
    endtask

    initial begin
        // Reset
        RESET_N = 1'b0;
        tick();
        check("rst_HRQ",   8'(HRQ),        8'h00);
        check("rst_DACK",  8'(DACK),       8'h00);
        check("rst_gv",    8'(grantValid), 8'h00);
        check("rst_ch",    8'(grantCh),    8'h00);
        check("rst_order", priorityOrder,  8'b11_10_01_00);
        RESET_N = 1'b1;

        // Fixed mode, channel 1 wins over channel 2
        DREQ = 4'b0110;
        tick();
        check("fix_HRQ", 8'(HRQ), 8'h01);
        tick();
        HLDA = 1'b1;
        tick();
        check("fix_DACK", 8'(DACK), 8'h02);
        check("fix_ch",   8'(grantCh), 8'h01);
        tick();
        transferDone = 1'b1;
        tick();
        check("fix_done_DACK", 8'(DACK), 8'h00);
        check("fix_done_HRQ",  8'(HRQ),  8'h00);
        transferDone = 1'b0; DREQ = 4'b0; HLDA = 1'b0;
        tick();

        // Rotating mode: serve channel 0, then channel 1 leads
        priorityType = 1'b1;
        DREQ = 4'b0001;
        tick();
        HLDA = 1'b1;
        tick();
        transferDone = 1'b1; DREQ = 4'b0;
        tick();
        check("rot_order", priorityOrder, 8'b00_11_10_01);
        transferDone = 1'b0; HLDA = 1'b0; DREQ = 4'b1111;
        tick();
        HLDA = 1'b1;
        tick();
        check("rot_DACK", 8'(DACK), 8'h02);
        transferDone = 1'b1; DREQ = 4'b0;
        tick();
        transferDone = 1'b0; HLDA = 1'b0;
        tick();

        // Masked hardware request ignored, software request honoured
        priorityType = 1'b0;
        maskReg = 4'b0001; DREQ = 4'b0001;
        tick(); tick(); tick();
        check("mask_HRQ", 8'(HRQ), 8'h00);
        requestReg = 4'b0001;
        tick();
        check("swreq_HRQ", 8'(HRQ), 8'h01);
        HLDA = 1'b1;
        tick();
        check("swreq_DACK", 8'(DACK), 8'h01);
        transferDone = 1'b1; requestReg = 4'b0; maskReg = 4'b0; DREQ = 4'b0;
        tick();
        transferDone = 1'b0; HLDA = 1'b0;
        tick();

        // Active-low DREQ: only channel 2 asserted
        dreqSenseLow = 1'b1; DREQ = 4'b1011;
        tick();
        HLDA = 1'b1;
        tick();
        check("low_DACK", 8'(DACK), 8'h04);
        transferDone = 1'b1; dreqSenseLow = 1'b0; DREQ = 4'b0;
        tick();
        transferDone = 1'b0; HLDA = 1'b0;
        tick();

        // HLDA drop during service of channel 3 aborts without rotation
        priorityType = 1'b1; DREQ = 4'b1000;
        tick();
        HLDA = 1'b1;
        tick();
        check("abort_pre_DACK", 8'(DACK), 8'h08);
        saved_order = priorityOrder;
        HLDA = 1'b0;
        tick();
        check("abort_DACK",  8'(DACK), 8'h00);
        check("abort_order", priorityOrder, saved_order);
        DREQ = 4'b0;
        tick();

        // Reset during service restores defaults after a rotation
        DREQ = 4'b0100;
        tick();
        HLDA = 1'b1;
        tick();
        transferDone = 1'b1;
        tick();
        check("rot2_order", priorityOrder, 8'b10_01_00_11);
        transferDone = 1'b0; HLDA = 1'b0;
        tick();
        HLDA = 1'b1;
        tick();
        check("pre_rst_gv", 8'(grantValid), 8'h01);
        RESET_N = 1'b0;
        tick();
        check("mid_rst_HRQ",   8'(HRQ),        8'h00);
        check("mid_rst_DACK",  8'(DACK),       8'h00);
        check("mid_rst_gv",    8'(grantValid), 8'h00);
        check("mid_rst_order", priorityOrder,  8'b11_10_01_00);
        RESET_N = 1'b1; DREQ = 4'b0; HLDA = 1'b0; priorityType = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            RESET_N = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
            if ($urandom_range(0, 15) == 0) dreqSenseLow = ~dreqSenseLow;
            if ($urandom_range(0, 31) == 0) priorityType = ~priorityType;
            controllerDisable = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) maskReg = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 5) == 0) requestReg = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 5) == 0) HLDA = (m_phase == 0);
            else                           HLDA = (m_phase != 0);
            transferDone = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
